// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between two valid/ready requesters.
//
// Round-robin arbitration picks a requester while idle. The chosen operands
// and opcode are registered onto the ALU inputs. The ALU has a one-clock
// registered latency, so its result is captured one cycle later. The result
// and flags then go back to the owner as a one-cycle response pulse.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req{0,1}_valid/_ready       request handshake (ready is combinational)
//   req{0,1}_op/_a/_b           requested opcode and operands
//   resp{0,1}_valid             one-cycle result pulse for the owner
//   resp_data/_carry/_zero      captured ALU result; held until the next capture
//   alu_a/alu_b/alu_op          registered drive to the ALU inputs
//   alu_result/_carry/_zero     ALU registered outputs
//   busy                        high while an operation is in flight
module alu_arbiter #(
  parameter int          N      = 8,
  parameter logic [3:0]  NOP_OP = 4'h0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [3:0]   req0_op,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [3:0]   req1_op,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         resp0_valid,
  output logic         resp1_valid,
  output logic [N-1:0] resp_data,
  output logic         resp_carry,
  output logic         resp_zero,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_op,
  input  logic [N-1:0] alu_result,
  input  logic         alu_carry,
  input  logic         alu_zero,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    CAPT
  } state_t;

  state_t state;
  logic   last_grant;
  logic   owner;

  logic   grant_valid;
  logic   grant_sel;

  // Contention goes to the requester that did not win last time.
  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_valid = 1'b1;
      grant_sel   = ~last_grant;
    end else if (req0_valid) begin
      grant_valid = 1'b1;
      grant_sel   = 1'b0;
    end else if (req1_valid) begin
      grant_valid = 1'b1;
      grant_sel   = 1'b1;
    end
  end

  assign req0_ready = (state == IDLE) && grant_valid && !grant_sel;
  assign req1_ready = (state == IDLE) && grant_valid &&  grant_sel;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= NOP_OP;
      resp_data   <= '0;
      resp_carry  <= 1'b0;
      resp_zero   <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
    end else begin
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            if (grant_sel) begin
              alu_a  <= req1_a;
              alu_b  <= req1_b;
              alu_op <= req1_op;
            end else begin
              alu_a  <= req0_a;
              alu_b  <= req0_b;
              alu_op <= req0_op;
            end
            owner      <= grant_sel;
            last_grant <= grant_sel;
            state      <= EXEC;
          end else begin
            alu_op <= NOP_OP;
          end
        end
        // The ALU registers the held operands at the end of this cycle.
        EXEC: state <= CAPT;
        CAPT: begin
          resp_data   <= alu_result;
          resp_carry  <= alu_carry;
          resp_zero   <= alu_zero;
          resp0_valid <= ~owner;
          resp1_valid <= owner;
          alu_op      <= NOP_OP;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
